// File: rtl/issue_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : issue_buffer_pkg
//  Purpose  : Shared launch_flag bit indices and helpers for the issue buffer
//             and the launch/select logic that drives it.
//  Revision : 1.0  initial release
// ============================================================================
package issue_buffer_pkg;

    // launch_flag bit positions: instruction slot -> execution unit
    localparam int LF_I1_E1 = 3;
    localparam int LF_I1_E2 = 2;
    localparam int LF_I2_E1 = 1;
    localparam int LF_I2_E2 = 0;

    // Number of valid slots in a two-bit valid vector
    function automatic logic [1:0] slot_count(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage : issue_buffer_pkg
`default_nettype wire

// File: rtl/issue_buf_ram.sv
`default_nettype none
// ============================================================================
//  Module   : issue_buf_ram
//  Purpose  : Entry storage for the issue buffer. Two write ports (tail and
//             tail+1) and two asynchronous read ports (head and head+1).
//             Data is not reset; validity is tracked by the pointer logic.
//  Revision : 1.0  initial release
// ============================================================================
module issue_buf_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 131
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  logic [W-1:0]  wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  logic [W-1:0]  wdata1,
    input  logic [AW-1:0] raddr0,
    output logic [W-1:0]  rdata0,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata1
);

    logic [W-1:0] r_mem [DEPTH];

    // Write both ports; the addresses always differ when both are enabled
    always_ff @(posedge clk) begin
        if (we0) r_mem[waddr0] <= wdata0;
        if (we1) r_mem[waddr1] <= wdata1;
    end

    assign rdata0 = r_mem[raddr0];
    assign rdata1 = r_mem[raddr1];

endmodule : issue_buf_ram
`default_nettype wire

// File: rtl/issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : issue_buffer
//  Purpose  : Dual-push / dual-pop circular instruction buffer between decode
//             and launch/select. Presents the two oldest entries as launch
//             candidates and retires 0..2 entries per cycle from launch_flag.
//  Revision : 1.0  initial release
// ============================================================================
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 67
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [PC_W-1:0]            in1_pc,
    input  logic [PC_W-1:0]            in1_npc,
    input  logic [DC_W-1:0]            in1_decodeout,
    input  logic [PC_W-1:0]            in2_pc,
    input  logic [PC_W-1:0]            in2_npc,
    input  logic [DC_W-1:0]            in2_decodeout,
    output logic                       in_ready,
    output logic [PC_W-1:0]            out1_pc,
    output logic [PC_W-1:0]            out1_npc,
    output logic [DC_W-1:0]            out1_decodeout,
    output logic                       receive_flag1,
    output logic [PC_W-1:0]            out2_pc,
    output logic [PC_W-1:0]            out2_npc,
    output logic [DC_W-1:0]            out2_decodeout,
    output logic                       receive_flag2,
    input  logic [3:0]                 launch_flag,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       protocol_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2*PC_W + DC_W;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_protocol_err;

    logic [CW-1:0] w_free;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;
    logic          w_l1;
    logic          w_l2;
    logic          w_pop1;
    logic          w_pop2;
    logic          w_illegal;
    logic          w_we0;
    logic          w_we1;
    logic [EW-1:0] w_wdata0;
    logic [EW-1:0] w_wdata1;
    logic [EW-1:0] w_rdata0;
    logic [EW-1:0] w_rdata1;
    logic [AW-1:0] w_tail_p1;
    logic [AW-1:0] w_head_p1;

    // Free space is taken from the registered count only, so a pop in the
    // same cycle never opens the input early.
    assign w_free   = CW'(DEPTH) - r_count;
    assign in_ready = (w_free >= CW'(2));

    assign receive_flag1 = (r_count >= CW'(1));
    assign receive_flag2 = (r_count >= CW'(2));

    // Push: a lone slot2 is written at tail just like a lone slot1
    assign w_push_n  = in_ready ? slot_count(in_valid) : 2'd0;
    assign w_we0     = in_ready & (|in_valid);
    assign w_we1     = in_ready & (&in_valid);
    assign w_wdata0  = in_valid[0] ? {in1_pc, in1_npc, in1_decodeout}
                                   : {in2_pc, in2_npc, in2_decodeout};
    assign w_wdata1  = {in2_pc, in2_npc, in2_decodeout};
    assign w_tail_p1 = r_tail + AW'(1);
    assign w_head_p1 = r_head + AW'(1);

    // Pop: inst2 only retires alongside inst1, and each term is masked by
    // its valid flag so the pop count can never exceed the occupancy.
    assign w_l1    = launch_flag[LF_I1_E1] | launch_flag[LF_I1_E2];
    assign w_l2    = launch_flag[LF_I2_E1] | launch_flag[LF_I2_E2];
    assign w_pop1  = w_l1 & receive_flag1;
    assign w_pop2  = w_l1 & w_l2 & receive_flag2;
    assign w_pop_n = {1'b0, w_pop1} + {1'b0, w_pop2};

    assign w_illegal = (w_l2 & ~w_l1)
                     | (launch_flag[LF_I1_E1] & launch_flag[LF_I1_E2])
                     | (launch_flag[LF_I2_E1] & launch_flag[LF_I2_E2])
                     | (w_l1 & ~receive_flag1)
                     | (w_l2 & ~receive_flag2);

    issue_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_ram (
        .clk    (clk),
        .we0    (w_we0),
        .waddr0 (r_tail),
        .wdata0 (w_wdata0),
        .we1    (w_we1),
        .waddr1 (w_tail_p1),
        .wdata1 (w_wdata1),
        .raddr0 (r_head),
        .rdata0 (w_rdata0),
        .raddr1 (w_head_p1),
        .rdata1 (w_rdata1)
    );

    // Pointer, count and error-pulse update; reset and flush win over traffic
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_head         <= r_head + AW'(w_pop_n);
            r_tail         <= r_tail + AW'(w_push_n);
            r_count        <= r_count + CW'(w_push_n) - CW'(w_pop_n);
            r_protocol_err <= w_illegal;
        end
    end

    // Candidate outputs are forced to zero whenever their slot is empty
    always_comb begin
        out1_pc        = '0;
        out1_npc       = '0;
        out1_decodeout = '0;
        out2_pc        = '0;
        out2_npc       = '0;
        out2_decodeout = '0;
        if (receive_flag1) begin
            out1_pc        = w_rdata0[EW-1 -: PC_W];
            out1_npc       = w_rdata0[DC_W+PC_W-1 -: PC_W];
            out1_decodeout = w_rdata0[DC_W-1:0];
        end
        if (receive_flag2) begin
            out2_pc        = w_rdata1[EW-1 -: PC_W];
            out2_npc       = w_rdata1[DC_W+PC_W-1 -: PC_W];
            out2_decodeout = w_rdata1[DC_W-1:0];
        end
    end

    assign occupancy    = r_count;
    assign protocol_err = r_protocol_err;

endmodule : issue_buffer
`default_nettype wire

// File: tb/tb_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_buffer
//  Purpose  : Directed self-checking bench for issue_buffer (DEPTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_buffer;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int DC_W  = 67;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [1:0]      in_valid;
    logic [PC_W-1:0] in1_pc, in1_npc, in2_pc, in2_npc;
    logic [DC_W-1:0] in1_decodeout, in2_decodeout;
    logic            in_ready;
    logic [PC_W-1:0] out1_pc, out1_npc, out2_pc, out2_npc;
    logic [DC_W-1:0] out1_decodeout, out2_decodeout;
    logic            receive_flag1, receive_flag2;
    logic [3:0]      launch_flag;
    logic [3:0]      occupancy;
    logic            protocol_err;

    int checks   = 0;
    int failures = 0;

    issue_buffer #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .DC_W  (DC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in1_pc         (in1_pc),
        .in1_npc        (in1_npc),
        .in1_decodeout  (in1_decodeout),
        .in2_pc         (in2_pc),
        .in2_npc        (in2_npc),
        .in2_decodeout  (in2_decodeout),
        .in_ready       (in_ready),
        .out1_pc        (out1_pc),
        .out1_npc       (out1_npc),
        .out1_decodeout (out1_decodeout),
        .receive_flag1  (receive_flag1),
        .out2_pc        (out2_pc),
        .out2_npc       (out2_npc),
        .out2_decodeout (out2_decodeout),
        .receive_flag2  (receive_flag2),
        .launch_flag    (launch_flag),
        .occupancy      (occupancy),
        .protocol_err   (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a two-slot push with npc = pc + 4 and decodeout = pc
    task automatic drive(input logic [1:0] v, input logic [31:0] p1, input logic [31:0] p2);
        in_valid      = v;
        in1_pc        = p1;
        in1_npc       = p1 + 32'd4;
        in1_decodeout = DC_W'(p1);
        in2_pc        = p2;
        in2_npc       = p2 + 32'd4;
        in2_decodeout = DC_W'(p2);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        launch_flag = 4'b0000;
        drive(2'b00, 32'h0, 32'h0);
        step();
        step();

        // Reset state
        check("rst_rf1",   receive_flag1, 1'b0);
        check("rst_rf2",   receive_flag2, 1'b0);
        check("rst_ready", in_ready,      1'b1);
        check("rst_occ",   occupancy,     4'd0);
        check("rst_pc1",   out1_pc,       32'h0);
        check("rst_perr",  protocol_err,  1'b0);
        rst_n = 1'b1;

        // Dual push then dual pop
        drive(2'b11, 32'h100, 32'h104);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("push_rf1",  receive_flag1,  1'b1);
        check("push_rf2",  receive_flag2,  1'b1);
        check("push_pc1",  out1_pc,        32'h100);
        check("push_pc2",  out2_pc,        32'h104);
        check("push_npc2", out2_npc,       32'h108);
        check("push_dc2",  out2_decodeout, 67'h104);
        check("push_occ",  occupancy,      4'd2);
        launch_flag = 4'b1001;
        step();
        launch_flag = 4'b0000;
        check("pop2_occ",  occupancy,     4'd0);
        check("pop2_rf1",  receive_flag1, 1'b0);
        check("pop2_rf2",  receive_flag2, 1'b0);
        check("pop2_pc1",  out1_pc,       32'h0);

        // Single pop of inst1 (head=2)
        drive(2'b11, 32'h200, 32'h204);
        step();
        drive(2'b00, 32'h0, 32'h0);
        launch_flag = 4'b0100;
        step();
        launch_flag = 4'b0000;
        check("pop1_pc1",  out1_pc,       32'h204);
        check("pop1_occ",  occupancy,     4'd1);
        check("pop1_rf2",  receive_flag2, 1'b0);
        check("pop1_perr", protocol_err,  1'b0);
        launch_flag = 4'b1000;
        step();
        launch_flag = 4'b0000;
        check("drain_occ", occupancy, 4'd0);

        // Fill from head=tail=4: pcs 0x300..0x31c land at indices 4..7,0..3
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h300 + 32'(8*i), 32'h304 + 32'(8*i));
            step();
        end
        check("full_occ",   occupancy, 4'd8);
        check("full_ready", in_ready,  1'b0);
        drive(2'b11, 32'h400, 32'h404);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("ovf_occ", occupancy, 4'd8);
        check("ovf_pc1", out1_pc,   32'h300);
        launch_flag = 4'b1001;
        step();
        launch_flag = 4'b0000;
        check("unfull_ready", in_ready,  1'b1);
        check("unfull_occ",   occupancy, 4'd6);
        check("unfull_pc1",   out1_pc,   32'h308);

        // Move head to 7 so the two candidates straddle the wrap
        launch_flag = 4'b1000;
        step();
        launch_flag = 4'b0000;
        check("wrap_pc1", out1_pc,   32'h30c);
        check("wrap_pc2", out2_pc,   32'h310);
        check("wrap_occ", occupancy, 4'd5);

        // Dual pop across the wrap with a simultaneous dual push at tail=4
        launch_flag = 4'b1001;
        drive(2'b11, 32'h500, 32'h504);
        step();
        launch_flag = 4'b0000;
        drive(2'b00, 32'h0, 32'h0);
        check("wrapx_occ", occupancy, 4'd5);
        check("wrapx_pc1", out1_pc,   32'h314);
        check("wrapx_pc2", out2_pc,   32'h318);
        launch_flag = 4'b0110;
        step();
        check("drn1_pc1", out1_pc, 32'h31c);
        check("drn1_pc2", out2_pc, 32'h500);
        step();
        launch_flag = 4'b0000;
        check("drn2_pc1", out1_pc,       32'h504);
        check("drn2_occ", occupancy,     4'd1);
        check("drn2_rf2", receive_flag2, 1'b0);

        // Illegal: inst2 without inst1 pops nothing
        launch_flag = 4'b0010;
        step();
        launch_flag = 4'b0000;
        check("ill1_perr", protocol_err, 1'b1);
        check("ill1_occ",  occupancy,    4'd1);
        step();
        check("ill1_pulse", protocol_err, 1'b0);

        // Illegal: two launches with only one entry pops only one
        launch_flag = 4'b1001;
        step();
        launch_flag = 4'b0000;
        check("ill2_perr", protocol_err, 1'b1);
        check("ill2_occ",  occupancy,    4'd0);
        step();
        check("ill2_pulse", protocol_err, 1'b0);

        // Build occupancy 5 from head=tail=6; lone slot2 push lands at tail
        drive(2'b11, 32'h600, 32'h604);
        step();
        drive(2'b11, 32'h608, 32'h60c);
        step();
        drive(2'b10, 32'h0, 32'h618);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("b5_occ", occupancy, 4'd5);
        check("b5_pc1", out1_pc,   32'h600);
        launch_flag = 4'b1001;
        step();
        step();
        launch_flag = 4'b0000;
        check("b5_last_pc1", out1_pc,       32'h618);
        check("b5_last_rf2", receive_flag2, 1'b0);
        drive(2'b11, 32'h700, 32'h704);
        step();
        drive(2'b11, 32'h708, 32'h70c);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("b5b_occ", occupancy, 4'd5);

        // Flush beats a concurrent push and launch
        flush       = 1'b1;
        launch_flag = 4'b1001;
        drive(2'b11, 32'h800, 32'h804);
        step();
        flush       = 1'b0;
        launch_flag = 4'b0000;
        drive(2'b00, 32'h0, 32'h0);
        check("fl_occ",   occupancy,     4'd0);
        check("fl_rf1",   receive_flag1, 1'b0);
        check("fl_rf2",   receive_flag2, 1'b0);
        check("fl_ready", in_ready,      1'b1);
        check("fl_perr",  protocol_err,  1'b0);

        // Mid-stream reset also clears a pending protocol error
        drive(2'b11, 32'h900, 32'h904);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("mr_occ0", occupancy, 4'd2);
        check("mr_pc1",  out1_pc,   32'h900);
        launch_flag = 4'b0010;
        step();
        launch_flag = 4'b0000;
        check("mr_perr1", protocol_err, 1'b1);
        launch_flag = 4'b0010;
        rst_n       = 1'b0;
        drive(2'b11, 32'ha00, 32'ha04);
        step();
        rst_n       = 1'b1;
        launch_flag = 4'b0000;
        drive(2'b00, 32'h0, 32'h0);
        check("mr_occ",   occupancy,     4'd0);
        check("mr_rf1",   receive_flag1, 1'b0);
        check("mr_ready", in_ready,      1'b1);
        check("mr_perr",  protocol_err,  1'b0);
        check("mr_pc1z",  out1_pc,       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_issue_buffer
`default_nettype wire
